// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the audio SRAM arbiter (state encoding, requester
// indices, SRAM bus widths).
package sram_arb_pkg;

  localparam int REQ_CHOR = 0;
  localparam int REQ_DEL  = 1;
  localparam int REQ_LOOP = 2;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  // IDLE encodes as zero so the debug state port reads 0 out of reset.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Round-robin winner selection: the search starts one above i_last and wraps,
// returning a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic             w_hi_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  // Descending scans leave the lowest matching index in each half: above the
  // pointer first, then wrapped round to the bottom.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (i > int'(i_last)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end else begin
          w_lo_idx = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    o_any = |i_req;
    o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between NREQ audio requesters; every access is SETUP/XFER/HOLD.
// Optional power-up zero sweep is compiled in with the SRAM_ARB_CLEAR_EN macro.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int CLEAR_DEPTH = 1048576
) (
  input  logic                   i_AUD_BCLK,
  input  logic                   i_rst_n,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ-1:0]        i_we_n,
  input  logic [NREQ*ADDR_W-1:0] i_addr,
  input  logic [NREQ*DATA_W-1:0] i_wdata,
  output logic [NREQ-1:0]        o_gnt,
  output logic [NREQ-1:0]        o_ack,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [ADDR_W-1:0]      o_SRAM_ADDR,
  output logic                   o_SRAM_WE_N,
  output logic                   o_dq_oe,
  output logic [DATA_W-1:0]      o_dq_out,
  input  logic [DATA_W-1:0]      i_dq_in,
  output logic                   o_busy,
  output logic                   o_clear_done,
  output state_t                 o_dbg_state
);

  // Handshake: a requester raises i_req with stable we_n/addr/wdata and keeps it
  // up until its o_ack pulse; the access is captured at selection, so dropping
  // i_req afterwards still completes the access and its o_ack.

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SRAM_ARB_CLEAR_EN
  localparam state_t ST_RESET = ST_CLEAR;
`else
  localparam state_t ST_RESET = ST_IDLE;
`endif

  if (CLEAR_DEPTH < 1 || CLEAR_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("sram_arbiter: CLEAR_DEPTH must lie in 1..2**ADDR_W");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_win_idx;
  logic [NREQ-1:0]   r_win_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we_n;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_clear_done;

  logic [NREQ-1:0]   w_arb_mask;
  logic [NREQ-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_arb_any;
  logic              w_load;
  logic              w_active;

`ifdef SRAM_ARB_CLEAR_EN
  // Clear phase: 0 = arm (bus quiet), 1 = setup, 2 = write strobe, 3 = hold.
  logic [1:0]        r_clr_ph;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              w_clr_last;

  assign w_clr_last = (r_clr_addr == ADDR_W'(CLEAR_DEPTH - 1));
`endif

  // In HOLD the current winner is masked out: it only re-arbitrates from IDLE.
  assign w_arb_mask = (r_state == ST_HOLD) ? (i_req & ~r_win_gnt) : i_req;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req  (w_arb_mask),
    .i_last (r_win_idx),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_arb_idx),
    .o_any  (w_arb_any)
  );

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_any) begin
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
        end
      end
      ST_SETUP: w_state_nxt = ST_XFER;
      ST_XFER:  w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_arb_any) begin
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
`ifdef SRAM_ARB_CLEAR_EN
        if (r_clr_ph == 2'd3 && w_clr_last) begin
          w_state_nxt = ST_IDLE;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The winner's access is frozen here; the round-robin pointer is r_win_idx.
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_idx <= IDX_W'(NREQ - 1);
      r_win_gnt <= '0;
      r_addr    <= '0;
      r_we_n    <= 1'b1;
      r_wdata   <= '0;
    end else if (w_load) begin
      r_win_idx <= w_arb_idx;
      r_win_gnt <= w_arb_gnt;
      r_addr    <= i_addr[int'(w_arb_idx)*ADDR_W +: ADDR_W];
      r_we_n    <= i_we_n[w_arb_idx];
      r_wdata   <= i_wdata[int'(w_arb_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (r_state == ST_XFER && r_we_n) begin
      r_rdata <= i_dq_in;
    end
  end

`ifdef SRAM_ARB_CLEAR_EN
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_ph   <= 2'd0;
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_ph == 2'd3) begin
        r_clr_ph <= 2'd1;
        if (!w_clr_last) begin
          r_clr_addr <= r_clr_addr + 1'b1;
        end
      end else begin
        r_clr_ph <= r_clr_ph + 2'd1;
      end
    end
  end
`endif

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clear_done <= 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
    end else if (r_state == ST_CLEAR && w_state_nxt == ST_IDLE) begin
      r_clear_done <= 1'b1;
`else
    end else begin
      r_clear_done <= 1'b1;
`endif
    end
  end

  assign w_active = (r_state == ST_SETUP) || (r_state == ST_XFER) || (r_state == ST_HOLD);

  // Pins decode straight from the async-reset state, so reset quiets the bus at once.
  always_comb begin
    o_SRAM_ADDR = '0;
    o_SRAM_WE_N = 1'b1;
    o_dq_oe     = 1'b0;
    o_dq_out    = '0;
    o_gnt       = '0;
    o_ack       = '0;
    if (w_active) begin
      o_SRAM_ADDR = r_addr;
      o_dq_oe     = ~r_we_n;
      o_dq_out    = r_wdata;
      o_gnt       = r_win_gnt;
      if (r_state == ST_XFER && !r_we_n) begin
        o_SRAM_WE_N = 1'b0;
      end
      if (r_state == ST_HOLD) begin
        o_ack = r_win_gnt;
      end
    end
`ifdef SRAM_ARB_CLEAR_EN
    if (r_state == ST_CLEAR && r_clr_ph != 2'd0) begin
      o_SRAM_ADDR = r_clr_addr;
      o_dq_oe     = 1'b1;
      o_SRAM_WE_N = (r_clr_ph != 2'd2);
    end
`endif
  end

  assign o_rdata      = r_rdata;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_clear_done = r_clear_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM; also covers the
// SRAM_ARB_CLEAR_EN build when that macro is defined.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we_n;
  logic [NREQ*20-1:0] addr;
  logic [NREQ*16-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [15:0]       rdata;
  logic [19:0]       sram_addr;
  logic              sram_we_n;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic [15:0]       dq_in;
  logic              busy;
  logic              clear_done;
  state_t            dbg_state;

  logic [15:0]       mem [0:1048575];
  logic              pre_we = 1'b0;
  logic [19:0]       pre_addr = '0;
  logic [15:0]       pre_data = '0;

  int n_checks = 0;
  int n_err = 0;
  int ack_cnt0 = 0;
  int ack_cnt2 = 0;
  int we_low_cnt = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .NREQ        (NREQ),
    .CLEAR_DEPTH (8)
  ) dut (
    .i_AUD_BCLK   (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_we_n       (we_n),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_gnt        (gnt),
    .o_ack        (ack),
    .o_rdata      (rdata),
    .o_SRAM_ADDR  (sram_addr),
    .o_SRAM_WE_N  (sram_we_n),
    .o_dq_oe      (dq_oe),
    .o_dq_out     (dq_out),
    .i_dq_in      (dq_in),
    .o_busy       (busy),
    .o_clear_done (clear_done),
    .o_dbg_state  (dbg_state)
  );

  // Behavioural SRAM: asynchronous read, write whenever WE_N is low at an edge.
  assign dq_in = mem[sram_addr];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (!sram_we_n && dq_oe) begin
      mem[sram_addr] <= dq_out;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack[0]) ack_cnt0 <= ack_cnt0 + 1;
      if (ack[2]) ack_cnt2 <= ack_cnt2 + 1;
      if (!sram_we_n) we_low_cnt <= we_low_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic on, input logic rd,
                         input logic [19:0] a, input logic [15:0] d);
    req[idx]            = on;
    we_n[idx]           = rd;
    addr[idx*20 +: 20]  = a;
    wdata[idx*16 +: 16] = d;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic reset_dut();
    int n;
    rst_n = 1'b0;
    req   = '0;
    we_n  = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (!clear_done && n < 100) begin
      tick();
      n++;
    end
    check("reset_ready", clear_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e;
    int w;
    int a0;
    int a2;
    int w0;

    req   = '0;
    we_n  = '1;
    addr  = '0;
    wdata = '0;

`ifdef SRAM_ARB_CLEAR_EN
    for (int i = 0; i < 8; i++) preload(20'(i), 16'hFFFF);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe", dq_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_out", dq_out, 0);
    check("rst_rdata", rdata, 0);
    check("rst_clear_done", clear_done, 0);
`ifdef SRAM_ARB_CLEAR_EN
    check("rst_busy", busy, 1);
    check("rst_state", dbg_state, ST_CLEAR);
`else
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
`endif
    rst_n = 1'b1;

`ifdef SRAM_ARB_CLEAR_EN
    // Sweep of 8 words: cycles 1..24, ready at 25; a request at cycle 3 waits.
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("clr_addr", sram_addr, (k - 1) / 3);
      check("clr_we_n", sram_we_n, ((k - 1) % 3 == 1) ? 0 : 1);
      check("clr_oe", dq_oe, 1);
      check("clr_data", dq_out, 0);
      check("clr_gnt", gnt, 0);
      check("clr_ack", ack, 0);
      check("clr_done_low", clear_done, 0);
      if (k == 3) set_req(0, 1'b1, 1'b1, 20'h00003, 16'h0);
    end
    tick();
    check("clr_done_c25", clear_done, 1);
    check("clr_busy_c25", busy, 0);
    check("clr_gnt_c25", gnt, 0);
    tick();
    check("clr_served_gnt", gnt, 3'b001);
    check("clr_served_addr", sram_addr, 20'h00003);
    tick();
    tick();
    check("clr_served_ack", ack, 3'b001);
    check("clr_served_rdata", rdata, 16'h0000);
    set_req(0, 1'b0, 1'b1, 20'h0, 16'h0);
    tick();
    check("clr_after_busy", busy, 0);
    for (int i = 0; i < 8; i++) check("clr_mem_zero", mem[i], 0);
`else
    check("done_c0", clear_done, 0);
    tick();
    check("done_c1", clear_done, 1);
`endif

    // Fresh reset so the round-robin pointer starts at NREQ-1 (index 0 first).
    reset_dut();
    preload(20'h00010, 16'h1234);

    set_req(0, 1'b1, 1'b1, 20'h00100, 16'h0);
    set_req(1, 1'b1, 1'b1, 20'h00101, 16'h0);
    set_req(2, 1'b1, 1'b1, 20'h00102, 16'h0);
    for (int k = 0; k < 18; k++) begin
      w = (k / 3) % 3;
      e = 3'b001 << w;
      tick();
      check("rr_gnt", gnt, e);
      check("rr_ack", ack, (k % 3 == 2) ? e : 3'b000);
      check("rr_busy", busy, 1);
      if (k % 3 == 0) check("rr_addr", sram_addr, 20'h00100 + w);
    end
    req = '0;
    tick();
    check("rr_idle_busy", busy, 0);
    check("rr_idle_gnt", gnt, 0);

    // Single read of requester 0.
    set_req(0, 1'b1, 1'b1, 20'h00010, 16'h0);
    tick();
    check("rd_setup_gnt", gnt, 3'b001);
    check("rd_setup_addr", sram_addr, 20'h00010);
    check("rd_setup_we_n", sram_we_n, 1);
    check("rd_setup_oe", dq_oe, 0);
    tick();
    check("rd_xfer_gnt", gnt, 3'b001);
    check("rd_xfer_we_n", sram_we_n, 1);
    check("rd_xfer_oe", dq_oe, 0);
    tick();
    check("rd_hold_ack", ack, 3'b001);
    check("rd_hold_gnt", gnt, 3'b001);
    check("rd_rdata", rdata, 16'h1234);
    set_req(0, 1'b0, 1'b1, 20'h0, 16'h0);
    tick();
    check("rd_idle_gnt", gnt, 0);
    check("rd_idle_ack", ack, 0);
    check("rd_idle_addr", sram_addr, 0);

    // Single write of requester 1.
    w0 = we_low_cnt;
    set_req(1, 1'b1, 1'b0, 20'hABCDE, 16'h5A5A);
    tick();
    check("wr_setup_gnt", gnt, 3'b010);
    check("wr_setup_addr", sram_addr, 20'hABCDE);
    check("wr_setup_we_n", sram_we_n, 1);
    check("wr_setup_oe", dq_oe, 1);
    check("wr_setup_data", dq_out, 16'h5A5A);
    tick();
    check("wr_xfer_we_n", sram_we_n, 0);
    check("wr_xfer_oe", dq_oe, 1);
    tick();
    check("wr_hold_we_n", sram_we_n, 1);
    check("wr_hold_oe", dq_oe, 1);
    check("wr_hold_ack", ack, 3'b010);
    set_req(1, 1'b0, 1'b1, 20'h0, 16'h0);
    tick();
    check("wr_idle_oe", dq_oe, 0);
    check("wr_idle_we_n", sram_we_n, 1);
    check("wr_we_low_cycles", we_low_cnt - w0, 1);
    check("wr_mem", mem[20'hABCDE], 16'h5A5A);

    // Requester 2 drops its request during XFER.
    a2 = ack_cnt2;
    set_req(2, 1'b1, 1'b1, 20'h00020, 16'h0);
    tick();
    check("drop_setup_gnt", gnt, 3'b100);
    tick();
    check("drop_xfer_gnt", gnt, 3'b100);
    req[2] = 1'b0;
    tick();
    check("drop_hold_ack", ack, 3'b100);
    tick();
    check("drop_idle_ack", ack, 0);
    check("drop_idle_busy", busy, 0);
    check("drop_ack_count", ack_cnt2 - a2, 1);

    // Reset lands mid-XFER of a write.
    a0 = ack_cnt0;
    set_req(0, 1'b1, 1'b0, 20'h00055, 16'hBEEF);
    tick();
    tick();
    check("rstw_xfer_we_n", sram_we_n, 0);
    check("rstw_xfer_oe", dq_oe, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_we_n", sram_we_n, 1);
    check("rstw_oe", dq_oe, 0);
    check("rstw_gnt", gnt, 0);
    check("rstw_ack", ack, 0);
    req  = '0;
    we_n = '1;
    tick();
    tick();
    check("rstw_no_ack", ack_cnt0 - a0, 0);
    check("rstw_no_write", (mem[20'h00055] == 16'hBEEF), 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
